input_event_scheduler: RTL

Frame-synchronous controller for the button input collector. On each frame tick it snapshots the collector's 10-bit sticky press/release flags and clears the collector. It then delivers the captured events one at a time to game logic over a valid/ready handshake: all presses first, then all releases. It sits between the input collector and the game state machine, and owns the collector's clear.

---
 rtl/input_event_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/input_event_scheduler.sv
// Frame-synchronous scheduler: snapshots the button collector on each frame tick,
// clears it, and delivers the captured events (presses first, then releases) over valid/ready.
module input_event_scheduler #(
   parameter int OVR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [9:0]       control_state,
   input  logic             frame_tick,
   output logic             collector_clear,
   output logic             event_valid,
   input  logic             event_ready,
   output logic [2:0]       event_button,
   output logic             event_pressed,
   output logic             frame_done,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_PRESS,
      ST_RELEASE
   } state_e;

   state_e           state_q, state_d;
   logic [4:0]       pend_p_q, pend_p_d;
   logic [4:0]       pend_r_q, pend_r_d;
   logic             clear_q, clear_d;
   logic             valid_q, valid_d;
   logic [2:0]       button_q, button_d;
   logic             pressed_q, pressed_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [OVR_W-1:0] overrun_q, overrun_d;
   logic             accept;

   function automatic logic [2:0] lsb_idx(input logic [4:0] v);
      lsb_idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (v[i]) lsb_idx = 3'(i);
      end
   endfunction

   assign accept = valid_q && event_ready;

   always_comb begin
      // NOTE: every signal gets a default first, so no branch can leave a latch behind.
      state_d   = state_q;
      pend_p_d  = pend_p_q;
      pend_r_d  = pend_r_q;
      clear_d   = 1'b0;
      valid_d   = valid_q;
      button_d  = button_q;
      pressed_d = pressed_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;

      if (frame_tick && state_q != ST_IDLE && overrun_q != {OVR_W{1'b1}}) begin
         overrun_d = overrun_q + OVR_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               state_d = ST_CAPTURE;
               clear_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            pend_p_d = control_state[9:5];
            pend_r_d = control_state[4:0];
            // An empty press half goes straight to releases; the first event is presented at once.
            if (control_state[9:5] != 5'd0) begin
               state_d   = ST_PRESS;
               valid_d   = 1'b1;
               button_d  = lsb_idx(control_state[9:5]);
               pressed_d = 1'b1;
            end else if (control_state[4:0] != 5'd0) begin
               state_d   = ST_RELEASE;
               valid_d   = 1'b1;
               button_d  = lsb_idx(control_state[4:0]);
               pressed_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_PRESS: begin
            if (accept) begin
               pend_p_d = pend_p_q & ~(5'd1 << button_q);
               valid_d  = 1'b0;
               if (pend_p_d == 5'd0) begin
                  if (pend_r_q != 5'd0) begin
                     state_d = ST_RELEASE;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end else if (!valid_q) begin
               valid_d   = 1'b1;
               button_d  = lsb_idx(pend_p_q);
               pressed_d = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (accept) begin
               pend_r_d = pend_r_q & ~(5'd1 << button_q);
               valid_d  = 1'b0;
               if (pend_r_d == 5'd0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (!valid_q) begin
               valid_d   = 1'b1;
               button_d  = lsb_idx(pend_r_q);
               pressed_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pend_p_q  <= '0;
         pend_r_q  <= '0;
         clear_q   <= 1'b0;
         valid_q   <= 1'b0;
         button_q  <= '0;
         pressed_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_p_q  <= pend_p_d;
         pend_r_q  <= pend_r_d;
         clear_q   <= clear_d;
         valid_q   <= valid_d;
         button_q  <= button_d;
         pressed_q <= pressed_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign collector_clear = clear_q;
   assign event_valid     = valid_q;
   assign event_button    = button_q;
   assign event_pressed   = pressed_q;
   assign frame_done      = done_q;
   assign busy            = busy_q;
   assign overrun_count   = overrun_q;

endmodule
